// File: rtl/w25q32jv_read_arbiter_if.sv
// Bundle of requester-side and fast-read-engine-side signals for the W25Q32JV read arbiter.
// The slave modport is the arbiter's view; master is the clients-plus-engine view.
interface w25q32jv_read_arbiter_if #(
  parameter int unsigned LEN_W = 8
);
  logic [1:0]       req;
  logic [23:0]      addr0;
  logic [23:0]      addr1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       gnt;
  logic [15:0]      rdata;
  logic [1:0]       rvalid;
  logic [1:0]       done;
  logic [1:0]       err;
  logic             busy;
  logic             fs_start;
  logic [23:0]      fs_addr;
  logic             fs_done;
  logic [7:0]       fs_data1;
  logic [7:0]       fs_data2;

  modport slave (
    input  req, addr0, addr1, len0, len1, fs_done, fs_data1, fs_data2,
    output gnt, rdata, rvalid, done, err, busy, fs_start, fs_addr
  );

  modport master (
    output req, addr0, addr1, len0, len1, fs_done, fs_data1, fs_data2,
    input  gnt, rdata, rvalid, done, err, busy, fs_start, fs_addr
  );
endinterface

// File: rtl/w25q32jv_read_arbiter.sv
// Round-robin arbiter sharing one W25Q32JV fast-read engine between two burst requesters;
// each burst is split into one engine command per 16-bit word with a per-word watchdog.
module w25q32jv_read_arbiter #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned TMO_CYC = 4096
) (
  input logic                    clk,
  input logic                    arstn,
  w25q32jv_read_arbiter_if.slave bus
);

  localparam int unsigned TmoW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StWait, StDeliver, StGap} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic             zlen_q, zlen_d;
  logic [23:0]      cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             fs_done_q;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             fs_start_q, fs_start_d;
  logic [23:0]      fs_addr_q, fs_addr_d;
  logic             fs_edge;
  logic             win;

  assign fs_edge = bus.fs_done & ~fs_done_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    zlen_d     = zlen_q;
    cur_addr_d = cur_addr_q;
    cur_len_d  = cur_len_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    gnt_d      = gnt_q;
    rdata_d    = rdata_q;
    fs_addr_d  = fs_addr_q;
    rvalid_d   = 2'b00;
    done_d     = 2'b00;
    err_d      = 2'b00;
    fs_start_d = 1'b0;
    win        = 1'b0;

    case (state_q)
      StIdle: begin
        if (zlen_q) begin
          // Zero-length burst: finish one cycle after the grant without touching the engine.
          done_d[owner_q] = 1'b1;
          gnt_d           = 2'b00;
          rr_d            = ~owner_q;
          zlen_d          = 1'b0;
        end else if (bus.req != 2'b00) begin
          win        = (&bus.req) ? rr_q : bus.req[1];
          owner_d    = win;
          gnt_d      = win ? 2'b10 : 2'b01;
          cur_addr_d = win ? bus.addr1 : bus.addr0;
          cur_len_d  = win ? bus.len1 : bus.len0;
          if (cur_len_d == '0) begin
            zlen_d = 1'b1;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        fs_start_d = 1'b1;
        fs_addr_d  = cur_addr_q;
        tmo_d      = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (fs_edge) begin
          rdata_d = {bus.fs_data1, bus.fs_data2};
          state_d = StDeliver;
        end else if (tmo_q == TmoW'(TMO_CYC - 1)) begin
          err_d[owner_q]  = 1'b1;
          done_d[owner_q] = 1'b1;
          gnt_d           = 2'b00;
          rr_d            = ~owner_q;
          cur_len_d       = '0;
          gap_d           = '0;
          state_d         = StGap;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDeliver: begin
        rvalid_d[owner_q] = 1'b1;
        cur_addr_d        = cur_addr_q + 24'd2;
        cur_len_d         = cur_len_q - LEN_W'(1);
        if (cur_len_d == '0) begin
          done_d[owner_q] = 1'b1;
          rr_d            = ~owner_q;
        end
        gap_d   = '0;
        state_d = StGap;
      end
      StGap: begin
        if (cur_len_q == '0) begin
          gnt_d = 2'b00;
        end
        if (gap_q == GapW'(GAP_CYC - 1)) begin
          state_d = (cur_len_q != '0) ? StStart : StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle) || zlen_d;
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      zlen_q     <= 1'b0;
      cur_addr_q <= '0;
      cur_len_q  <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      fs_done_q  <= 1'b0;
      gnt_q      <= 2'b00;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      fs_start_q <= 1'b0;
      fs_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      zlen_q     <= zlen_d;
      cur_addr_q <= cur_addr_d;
      cur_len_q  <= cur_len_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      fs_done_q  <= bus.fs_done;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fs_start_q <= fs_start_d;
      fs_addr_q  <= fs_addr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.fs_start = fs_start_q;
  assign bus.fs_addr  = fs_addr_q;

endmodule

// File: tb/tb_w25q32jv_read_arbiter.sv
// Directed bench for w25q32jv_read_arbiter: an engine model answers each fs_start with the
// low address bytes, a monitor logs events, and the main sequence checks them.
module tb_w25q32jv_read_arbiter;
  localparam int unsigned LenW = 8;
  localparam int unsigned Gap  = 4;
  localparam int unsigned Tmo  = 16;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  w25q32jv_read_arbiter_if #(.LEN_W(LenW)) bus ();

  w25q32jv_read_arbiter #(
    .LEN_W  (LenW),
    .GAP_CYC(Gap),
    .TMO_CYC(Tmo)
  ) dut (
    .clk  (clk),
    .arstn(arstn),
    .bus  (bus)
  );

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  bit eng_en = 1'b1;
  bit gnt_bad = 1'b0;
  logic [1:0] prev_gnt = 2'b00;
  logic prev_done = 1'b0;

  logic [23:0] st_addr[$];
  int          st_time[$];
  logic [15:0] rv_data[$];
  logic [1:0]  rv_who[$];
  int          rv_time[$];
  logic [3:0]  dn_rec[$];
  int          dn_time[$];
  logic [1:0]  gseq[$];
  int          rise_time[$];

  // Engine model: fs_done rises 3 cycles after fs_start, data = low byte of addr and addr+1.
  initial begin
    logic [23:0] a;
    logic [23:0] a1;
    bus.fs_done  = 1'b0;
    bus.fs_data1 = 8'h00;
    bus.fs_data2 = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.fs_start && eng_en) begin
        a = bus.fs_addr;
        a1 = a + 24'd1;
        repeat (3) @(posedge clk);
        #1;
        bus.fs_data1 = a[7:0];
        bus.fs_data2 = a1[7:0];
        bus.fs_done  = 1'b1;
        @(posedge clk);
        #1;
        bus.fs_done = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    cyc++;
    if (bus.fs_start) begin
      st_addr.push_back(bus.fs_addr);
      st_time.push_back(cyc);
    end
    if (bus.rvalid != 2'b00) begin
      rv_data.push_back(bus.rdata);
      rv_who.push_back(bus.rvalid);
      rv_time.push_back(cyc);
    end
    if (bus.done != 2'b00) begin
      dn_rec.push_back({bus.err, bus.done});
      dn_time.push_back(cyc);
    end
    if (bus.fs_done && !prev_done) rise_time.push_back(cyc);
    prev_done = bus.fs_done;
    if ($countones(bus.gnt) > 1) gnt_bad = 1'b1;
    if (bus.gnt != prev_gnt && bus.gnt != 2'b00) gseq.push_back(bus.gnt);
    prev_gnt = bus.gnt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    st_addr.delete(); st_time.delete();
    rv_data.delete(); rv_who.delete(); rv_time.delete();
    dn_rec.delete(); dn_time.delete();
    gseq.delete(); rise_time.delete();
    gnt_bad = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arstn = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic issue(input logic [1:0] r);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    #3;
    bus.req = 2'b00;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (bus.busy && n < bound) begin
      @(posedge clk);
      #3;
      n++;
    end
    chk(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    bus.req   = 2'b00;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.len0  = '0;
    bus.len1  = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_outs", {26'd0, bus.gnt, bus.rvalid, bus.done, bus.err, bus.busy, bus.fs_start},
        32'd0);
    chk("reset_rdata", {16'd0, bus.rdata}, 32'd0);
    chk("reset_fsaddr", {8'd0, bus.fs_addr}, 32'd0);
    @(negedge clk);
    arstn = 1'b1;

    // Three-word burst from requester 0.
    clear_q();
    bus.addr0 = 24'hAACCEE;
    bus.len0  = 8'd3;
    issue(2'b01);
    chk("t1_gnt", {30'd0, bus.gnt}, 32'h1);
    chk("t1_busy", {31'd0, bus.busy}, 32'h1);
    wait_idle("t1_idle", 200);
    chk("t1_nstart", st_addr.size(), 3);
    chk("t1_addr0", {8'd0, st_addr[0]}, 32'hAACCEE);
    chk("t1_addr1", {8'd0, st_addr[1]}, 32'hAACCF0);
    chk("t1_addr2", {8'd0, st_addr[2]}, 32'hAACCF2);
    chk("t1_nrv", rv_data.size(), 3);
    chk("t1_rd0", {16'd0, rv_data[0]}, 32'hEEEF);
    chk("t1_rd1", {16'd0, rv_data[1]}, 32'hF0F1);
    chk("t1_rd2", {16'd0, rv_data[2]}, 32'hF2F3);
    chk("t1_who", {26'd0, rv_who[0], rv_who[1], rv_who[2]}, 32'b010101);
    chk("t1_lat", rv_time[0] - rise_time[0], 2);
    chk("t1_ndone", dn_rec.size(), 1);
    chk("t1_done", {28'd0, dn_rec[0]}, 32'h1);
    chk("t1_done_t", dn_time[0], rv_time[2]);
    chk("t1_gseq", {30'd0, gseq[0]}, 32'h1);
    chk("t1_ngseq", gseq.size(), 1);
    chk("t1_rdata_hold", {16'd0, bus.rdata}, 32'hF2F3);

    // Both requesters held: round-robin 0,1,0,1 after a reset.
    do_reset();
    clear_q();
    bus.addr0 = 24'h000010;
    bus.addr1 = 24'h000020;
    bus.len0  = 8'd1;
    bus.len1  = 8'd1;
    @(negedge clk);
    bus.req = 2'b11;
    n = 0;
    while (dn_rec.size() < 4 && n < 600) begin
      @(posedge clk);
      #3;
      n++;
    end
    bus.req = 2'b00;
    chk("t2_ndone", dn_rec.size(), 4);
    wait_idle("t2_idle", 200);
    chk("t2_gseq", {24'd0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'b01100110);
    chk("t2_onehot", {31'd0, gnt_bad}, 32'd0);
    chk("t2_rd0", {16'd0, rv_data[0]}, 32'h1011);
    chk("t2_rd1", {16'd0, rv_data[1]}, 32'h2021);
    chk("t2_done", {16'd0, dn_rec[0], dn_rec[1], dn_rec[2], dn_rec[3]}, 32'h1212);

    // Address wrap at the top of the 24-bit space (rr now points at 0; only req1 asks).
    clear_q();
    bus.addr1 = 24'hFFFFFE;
    bus.len1  = 8'd2;
    issue(2'b10);
    chk("t3_gnt", {30'd0, bus.gnt}, 32'h2);
    wait_idle("t3_idle", 200);
    chk("t3_nstart", st_addr.size(), 2);
    chk("t3_addr0", {8'd0, st_addr[0]}, 32'hFFFFFE);
    chk("t3_addr1", {8'd0, st_addr[1]}, 32'h000000);
    chk("t3_rd", {rv_data[0], rv_data[1]}, 32'hFEFF0001);
    chk("t3_done", {28'd0, dn_rec[0]}, 32'h2);

    // Zero-length burst: done only, no engine access, rr moves to requester 1.
    clear_q();
    bus.len0 = 8'd0;
    issue(2'b01);
    wait_idle("t4_idle", 20);
    chk("t4_nstart", st_addr.size(), 0);
    chk("t4_nrv", rv_data.size(), 0);
    chk("t4_ndone", dn_rec.size(), 1);
    chk("t4_done", {28'd0, dn_rec[0]}, 32'h1);
    bus.len0 = 8'd1;
    bus.len1 = 8'd1;
    bus.addr1 = 24'h000030;
    issue(2'b11);
    chk("t4_rr", {30'd0, bus.gnt}, 32'h2);
    wait_idle("t4_idle2", 200);

    // Silent engine: watchdog aborts with err+done 16 cycles after fs_start.
    clear_q();
    eng_en = 1'b0;
    bus.addr0 = 24'h000100;
    bus.len0  = 8'd2;
    issue(2'b01);
    wait_idle("t5_idle", 200);
    chk("t5_nstart", st_addr.size(), 1);
    chk("t5_ndone", dn_rec.size(), 1);
    chk("t5_errdone", {28'd0, dn_rec[0]}, 32'h5);
    chk("t5_tmo_t", dn_time[0] - st_time[0], 16);
    chk("t5_nrv", rv_data.size(), 0);
    clear_q();
    eng_en = 1'b1;
    bus.addr0 = 24'h000344;
    bus.len0  = 8'd1;
    issue(2'b01);
    wait_idle("t5_idle2", 200);
    chk("t5_next_rd", {16'd0, rv_data[0]}, 32'h4445);
    chk("t5_next_done", {28'd0, dn_rec[0]}, 32'h1);

    // Reset while waiting on the engine.
    clear_q();
    eng_en = 1'b0;
    bus.addr0 = 24'h000400;
    bus.len0  = 8'd3;
    issue(2'b01);
    repeat (6) @(posedge clk);
    @(negedge clk);
    arstn = 1'b0;
    @(posedge clk);
    #3;
    chk("t6_outs", {26'd0, bus.gnt, bus.rvalid, bus.done, bus.err, bus.busy, bus.fs_start},
        32'd0);
    chk("t6_rdata", {8'd0, bus.fs_addr}, 32'd0);
    @(negedge clk);
    arstn = 1'b1;
    chk("t6_nodone", dn_rec.size(), 0);
    clear_q();
    eng_en = 1'b1;
    bus.addr0 = 24'h000500;
    bus.len0  = 8'd1;
    issue(2'b11);
    chk("t6_rr0", {30'd0, bus.gnt}, 32'h1);
    wait_idle("t6_idle", 200);
    chk("t6_rd", {16'd0, rv_data[0]}, 32'h0001);
    chk("t6_addr", {8'd0, st_addr[0]}, 32'h000500);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/w25q32jv_read_arbiter.md
Name: w25q32jv_read_arbiter

Overview:
- Shares one W25Q32JV fast-read engine between two burst requesters.
- Per grant, issues a sequence of fast-read commands: one start pulse per 16-bit word, auto-incrementing the address by 2 each time.
- Returns each word to the owning requester, with a per-word watchdog and round-robin fairness between bursts.
- Sits between client logic and the fast-read engine's start/addr/done/data ports.

Parameters:
- LEN_W, 8: width of burst length in 16-bit words (max 255 words).
- GAP_CYC, 4: minimum idle clk cycles between the engine's done edge and the next fs_start (csn high time).
- TMO_CYC, 4096: clk cycles allowed from fs_start to fs_done rising edge before abort.

Ports:
- clk  in  1  system clock.
- arstn  in  1  reset, synchronous, active-low.
- req  in  2  per-requester burst request; sampled only in IDLE.
- addr0  in  24  requester 0 start byte address.
- addr1  in  24  requester 1 start byte address.
- len0  in  LEN_W  requester 0 burst length (words).
- len1  in  LEN_W  requester 1 burst length (words).
- gnt  out  2  one-hot owner of current burst; level.
- rdata  out  16  returned word, shared by both requesters.
- rvalid  out  2  one-cycle pulse to the owner; rdata valid that cycle.
- done  out  2  one-cycle pulse at burst end.
- err  out  2  one-cycle pulse with done on timeout abort.
- busy  out  1  high whenever state is not IDLE.
- fs_start  out  1  one-cycle start pulse to the engine.
- fs_addr  out  24  engine address; stable from fs_start until done edge.
- fs_done  in  1  engine completion flag; rising edge is the event.
- fs_data1  in  8  engine byte at fs_addr.
- fs_data2  in  8  engine byte at fs_addr+1.

Behaviour:
- Reset (arstn=0 at posedge clk): all outputs 0, state IDLE, rr_ptr=0, fs_done edge register=0. Reset mid-burst aborts immediately, with no done/err pulse.
- States: IDLE, START, WAIT, DELIVER, GAP.
- IDLE:
  - If req!=0, choose a winner: if both requesters are set, pick the one indexed by rr_ptr, else the sole requester.
  - Latch cur_addr/cur_len from the winner, set gnt one-hot, busy=1.
  - If latched len==0: pulse done[winner] next cycle, drop gnt, toggle rr_ptr, return to IDLE with no engine access.
  - Otherwise go to START.
- START: fs_start=1 for exactly one cycle, fs_addr=cur_addr, clear tmo counter, go to WAIT.
- WAIT:
  - Detect fs_done rising edge (fs_done & ~fs_done_q).
  - On the edge: capture rdata={fs_data1,fs_data2} (first byte in MSB), go to DELIVER.
  - If tmo counter reaches TMO_CYC-1 with no edge: pulse err[owner] and done[owner] together, drop gnt, toggle rr_ptr, go to GAP.
- DELIVER:
  - rvalid[owner]=1 for one cycle.
  - cur_addr += 2, modulo 2^24 (24'hFFFFFE wraps to 24'h000000).
  - cur_len -= 1.
  - If the new len==0: done[owner] pulses in the same cycle, gnt drops the next cycle, rr_ptr toggles.
  - Go to GAP.
- GAP: count GAP_CYC cycles. Then, if burst ongoing, go to START; else go to IDLE.
- Timing:
  - Latency from fs_done edge to rvalid: 2 clk.
  - Word period: engine time + GAP_CYC + 2.
  - rdata holds its value until the next capture.
- rr_ptr: after any completed or aborted burst, points to the other requester.
- req changes during a burst are ignored. A req still high after done is a new request and competes under round-robin.
- fs_done already high on entry to WAIT produces no edge; the block waits for a new rising edge.
- addr/len inputs are used only on the IDLE grant cycle.

Test Plan:
- req=2'b01, addr0=24'hAACCEE, len0=3, engine model returns bytes of address → fs_start addresses AACCEE, AACCF0, AACCF2; rdata AACC/EEEF-style words match the model; 3 rvalid[0] pulses; done[0] with the third; gnt=01 throughout.
- req=2'b11 held, len0=len1=1 after reset → grants in order 0,1,0,1; each done followed by a gnt switch; never two gnt bits high.
- addr1=24'hFFFFFE, len1=2 → fs_addr FFFFFE then 000000.
- len0=0 → done[0] pulse, no fs_start, rr_ptr toggles.
- Engine never raises fs_done, TMO_CYC=16 → err[0] and done[0] pulse together 16 cycles after fs_start; next request is served normally.
- arstn low during WAIT → all outputs 0 next cycle, no done; a fresh request after reset starts cleanly with rr_ptr=0.
